// File: rtl/riscv_trace_capture_if.sv
// Trace output stream: one 32-bit word per valid/ready handshake.
// Ports: out_valid/out_data/out_last from capture block, out_ready from sink.
// The master modport is the trace source; the slave modport is the host/sink.
interface riscv_trace_capture_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/riscv_trace_capture.sv
// Purpose: samples core debug signals into a record FIFO while armed; drains 4 words/record.
// Latency: record pushed at edge N is visible on the stream right after edge N.
// Backpressure: out_ready low holds the current word; a full FIFO drops new records (counted).
// Ports: clk, rst (async active-low), dbg_* core sample, arm/stop pulses, trig_pc,
//   stream (riscv_trace_capture_if.master), state, level, overflow, drop_cnt.
// Build option: define TRACE_TRIG_EN so arm waits for dbg_pc == trig_pc before capturing.
module riscv_trace_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dbg_pc,
  input  logic [31:0]           dbg_instr,
  input  logic [31:0]           dbg_ALU_result,
  input  logic [3:0]            dbg_ALU_ctrl,
  input  logic                  dbg_wr_en,
  input  logic                  arm,
  input  logic                  stop,
  input  logic [31:0]           trig_pc,
  riscv_trace_capture_if.master stream,
  output logic [1:0]            state,
  output logic [ADDR_W:0]       level,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [3:0]  ctrl;
    logic        wr_en;
  } rec_t;

`ifdef TRACE_TRIG_EN
  localparam state_t ARM_STATE = S_WAIT;
`else
  localparam state_t ARM_STATE = S_CAPTURE;
`endif

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  state_t            cur_state, next_state;
  rec_t              mem [DEPTH];
  rec_t              rec_in, rd_rec;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]        word_idx;
  logic [31:0]       word;
  logic              push_req, rearm;
  logic              full, xfer, pop, push_ok, drop;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= S_IDLE;
    else      cur_state <= next_state;
  end

  // stop is checked before the trigger so a stop cycle never captures
  always_comb begin
    next_state = cur_state;
    push_req   = 1'b0;
    rearm      = 1'b0;
    case (cur_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          next_state = ARM_STATE;
          rearm      = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop) begin
          next_state = S_DONE;
        end else if (dbg_pc == trig_pc) begin
          push_req   = 1'b1;
          next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (stop) next_state = S_DONE;
        else      push_req   = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

  // ---------------- record FIFO ----------------
  assign rec_in = '{pc: dbg_pc, instr: dbg_instr, result: dbg_ALU_result,
                    ctrl: dbg_ALU_ctrl, wr_en: dbg_wr_en};

  assign full    = (level == FULL_LVL);
  assign xfer    = stream.out_valid && stream.out_ready;
  assign pop     = xfer && (word_idx == 2'd3);
  // When full, a same-edge pop frees the slot at rd_ptr, which equals wr_ptr
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      word_idx <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // word_idx wraps 3 -> 0 exactly on the popping handshake
      if (xfer)    word_idx <= word_idx + 2'd1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- drop accounting ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (rearm) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------- output stream ----------------
  assign rd_rec = mem[rd_ptr];

  always_comb begin
    word = 32'd0;
    case (word_idx)
      2'd0: word = rd_rec.pc;
      2'd1: word = rd_rec.instr;
      2'd2: word = rd_rec.result;
      2'd3: word = {27'd0, rd_rec.wr_en, rd_rec.ctrl};
      default: word = 32'd0;
    endcase
  end

  // Outputs depend only on registered state, so they hold while stalled
  assign stream.out_valid = (level != '0);
  assign stream.out_data  = stream.out_valid ? word : 32'd0;
  assign stream.out_last  = stream.out_valid && (word_idx == 2'd3);

endmodule

// File: tb/tb_riscv_trace_capture.sv
module tb_riscv_trace_capture;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

`ifdef TRACE_TRIG_EN
  localparam int ARM_ST = 1;
`else
  localparam int ARM_ST = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dbg_pc, dbg_instr, dbg_ALU_result, trig_pc;
  logic [3:0]  dbg_ALU_ctrl;
  logic        dbg_wr_en, arm, stop;
  logic [1:0]  state;
  logic [ADDR_W:0] level;
  logic        overflow;
  logic [15:0] drop_cnt;

  riscv_trace_capture_if sif ();

  riscv_trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_pc         (dbg_pc),
    .dbg_instr      (dbg_instr),
    .dbg_ALU_result (dbg_ALU_result),
    .dbg_ALU_ctrl   (dbg_ALU_ctrl),
    .dbg_wr_en      (dbg_wr_en),
    .arm            (arm),
    .stop           (stop),
    .trig_pc        (trig_pc),
    .stream         (sif),
    .state          (state),
    .level          (level),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of captured records plus the word being offered
  typedef struct {
    logic [31:0] pc, instr, res;
    logic [3:0]  ctrl;
    logic        wr;
  } rec_t;

  rec_t        q[$];
  int          widx;
  int          m_state;   // 0 idle, 1 wait, 2 capture, 3 done
  bit          m_ovf;
  int          m_drop;
  int          n_chk, n_fail;
  logic [31:0] pc_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    widx    = 0;
    m_state = 0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  function automatic logic [31:0] exp_word();
    if (q.size() == 0) return 32'd0;
    case (widx)
      0:       return q[0].pc;
      1:       return q[0].instr;
      2:       return q[0].res;
      default: return {27'd0, q[0].wr, q[0].ctrl};
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", sif.out_valid, q.size() != 0);
    chk("out_data",  sif.out_data, exp_word());
    chk("out_last",  sif.out_last, (q.size() != 0) && (widx == 3));
    chk("level",     level, q.size());
    chk("state",     state, m_state);
    chk("overflow",  overflow, m_ovf);
    chk("drop_cnt",  drop_cnt, m_drop);
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit   full, xfer, pop, push_req;
    rec_t r;
    full     = (q.size() == DEPTH);
    xfer     = (q.size() != 0) && sif.out_ready;
    pop      = xfer && (widx == 3);
    push_req = 0;
    r = '{pc: dbg_pc, instr: dbg_instr, res: dbg_ALU_result, ctrl: dbg_ALU_ctrl, wr: dbg_wr_en};
    if (m_state == 0 || m_state == 3) begin
      if (arm) begin
        m_state = ARM_ST;
        m_ovf   = 0;
        m_drop  = 0;
      end
    end else if (stop) begin
      m_state = 3;
    end else if (m_state == 2) begin
      push_req = 1;
    end else if (dbg_pc == trig_pc) begin
      push_req = 1;
      m_state  = 2;
    end
    if (xfer) begin
      if (pop) begin
        void'(q.pop_front());
        widx = 0;
      end else begin
        widx++;
      end
    end
    if (push_req) begin
      if (!full || pop) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  // One clock: apply inputs, check outputs before the edge, step the model
  task automatic cycle(input bit a, input bit s, input bit r);
    arm            = a;
    stop           = s;
    sif.out_ready  = r;
    dbg_pc         = pc_cnt;
    pc_cnt         = pc_cnt + 32'd4;
    dbg_instr      = $urandom;
    dbg_ALU_result = $urandom;
    dbg_ALU_ctrl   = 4'($urandom_range(0, 15));
    dbg_wr_en      = 1'($urandom_range(0, 1));
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Arm so that the trigger (when compiled in) hits on the next cycle
  task automatic arm_now(input bit r);
    trig_pc = pc_cnt + 32'd4;
    cycle(1, 0, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) cycle(0, 0, 1);
    chk("drain_empty", level, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    arm = 0; stop = 0; trig_pc = 0;
    sif.out_ready = 0;
    dbg_pc = 0; dbg_instr = 0; dbg_ALU_result = 0; dbg_ALU_ctrl = 0; dbg_wr_en = 0;
    pc_cnt = 32'hFFFF_FFFC;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Three records at PCs 0, 4, 8, then stop and drain at full rate
    arm_now(0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("t1_level", level, 3);
    chk("t1_state_done", state, 3);
    chk("t1_first_pc", sif.out_data, 32'h0);
    drain();

    // Single record held under backpressure
    arm_now(0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 0);
    drain();
    chk("t2_valid_low", sif.out_valid, 0);

    // Overflow: 20 captures into a 16-deep FIFO
    arm_now(0);
    repeat (20) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("t3_level", level, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 4);
    drain();
    chk("t3_ovf_sticky", overflow, 1);
    cycle(1, 0, 0);
    chk("t3_rearm_ovf", overflow, 0);
    chk("t3_rearm_drop", drop_cnt, 0);
    cycle(0, 1, 0);
    drain();

    // Full FIFO with the final-word pop landing on a capture edge
    arm_now(0);
    repeat (16) cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 1);
    arm_now(0);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    chk("t4_level", level, 16);
    chk("t4_drop", drop_cnt, 0);
    drain();

`ifdef TRACE_TRIG_EN
    // Trigger four cycles after arm
    trig_pc = pc_cnt + 32'd16;
    cycle(1, 0, 0);
    chk("t5_wait", state, 1);
    repeat (3) cycle(0, 0, 0);
    chk("t5_still_wait", state, 1);
    cycle(0, 0, 0);
    chk("t5_capture", state, 2);
    chk("t5_first_pc", sif.out_data, trig_pc);
    cycle(0, 1, 0);
    drain();
`endif

    // Randomised sessions with varying sink throughput
    for (int seg = 0; seg < 12; seg++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        bit a, s, r;
        a = ($urandom_range(0, 19) == 0);
        s = ($urandom_range(0, 24) == 0);
        r = ($urandom_range(1, 100) <= rdy_pct);
        if (a) trig_pc = pc_cnt + 32'd4 * 32'($urandom_range(0, 6));
        cycle(a, s, r);
      end
    end
    cycle(0, 1, 0);
    drain();

    // Asynchronous reset in the middle of a drain
    arm_now(0);
    repeat (5) cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (2) cycle(0, 0, 1);
    chk("t6_level_pre", level, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", sif.out_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_state", state, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_data", sif.out_data, 0);
    model_reset();
    #2;
    rst = 1'b1;
    repeat (4) cycle(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_trace_capture.md
Name: riscv_trace_capture

Overview:
Consumer end of the processor's debug port. Samples the per-cycle debug signals (pc, instr, ALU result/ctrl, write enable) into a trace FIFO while armed. Drains each record as four 32-bit words over a valid/ready stream toward a host or trace sink. Sits beside the core in the top level, replacing ad-hoc $monitor observation with synthesizable trace capture.

Parameters:
DEPTH, 16, record FIFO depth; power of two, >= 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
dbg_pc  in  32  core PC this cycle
dbg_instr  in  32  core instruction this cycle
dbg_ALU_result  in  32  core ALU result this cycle
dbg_ALU_ctrl  in  4  core ALU control this cycle
dbg_wr_en  in  1  core register write enable this cycle
arm  in  1  single-cycle pulse; start a capture session
stop  in  1  single-cycle pulse; end capture
trig_pc  in  32  trigger PC (used only with TRACE_TRIG_EN)
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts word
out_data  out  32  stream word
out_last  out  1  high on the 4th word of a record
state  out  2  00 IDLE, 01 WAIT, 10 CAPTURE, 11 DONE
level  out  ADDR_W+1  records held, 0..DEPTH
overflow  out  1  sticky; a record was dropped this session
drop_cnt  out  16  dropped records this session, saturates at 0xFFFF

Behaviour:
- Reset (rst=0, immediate): state=IDLE, FIFO empty, level=0, word index=0, out_valid=0, out_data=0, out_last=0, overflow=0, drop_cnt=0.
- IDLE: arm -> CAPTURE (or WAIT with TRACE_TRIG_EN). arm clears overflow and drop_cnt. It does not flush the FIFO. stop is ignored.
- WAIT: on an edge where dbg_pc==trig_pc, that cycle's record is captured and state -> CAPTURE.
- CAPTURE: every rising edge pushes one record {pc, instr, ALU_result, ALU_ctrl, wr_en} from the current dbg_* values.
- stop in WAIT/CAPTURE -> DONE. The record on the stop cycle is NOT captured. stop has priority over trigger.
- DONE: no capture. arm re-arms exactly as from IDLE.
- arm while in WAIT/CAPTURE is ignored.
- Full: a push with level==DEPTH and no same-edge pop is dropped; overflow<=1; drop_cnt++ (saturating).
- Same-edge pop (final word handshake) and push when full: push is accepted, level unchanged, no drop.
- Pointers are ADDR_W bits and wrap modulo DEPTH. level = push count minus pop count.
- Drain is independent of state; it continues in DONE and IDLE.
- out_valid = (level != 0). Latency: a record pushed at edge N gives out_valid=1 after edge N.
- Word order: 0 pc, 1 instr, 2 ALU_result, 3 {27'b0, wr_en, ALU_ctrl}. out_last=1 only on word 3.
- Transfer occurs on an edge with out_valid && out_ready. Word index then increments. On word 3, the record pops and index -> 0.
- out_data/out_last are stable while out_valid && !out_ready.
- out_data=0 and out_last=0 when out_valid=0.
- Records drain strictly in capture order.

Optional Feature:
TRACE_TRIG_EN
- Defined: arm enters WAIT; capture begins on the first cycle with dbg_pc==trig_pc, and that cycle's record is the first in the FIFO.
- Undefined: arm enters CAPTURE directly (first record is the cycle after arm); WAIT is never reached; trig_pc is unused.

Test Plan:
1. Reset, arm (no macro), PCs 0x0/0x4/0x8 with known instr/ALU values, then stop; out_ready=1 -> 12 words in order, out_last on words 4/8/12, word 4 = {27'b0, wr_en, ctrl}, level 3->0, state=DONE.
2. One record held, out_ready=0 for 5 cycles -> out_valid=1, out_data=pc and out_last=0 held constant; then out_ready=1 -> 4 words, out_valid=0.
3. DEPTH=16, out_ready=0, capture 20 cycles -> level=16, overflow=1, drop_cnt=4, drained PCs are the first 16 in order; next arm clears overflow and drop_cnt.
4. level=16, time out_ready so that word-3 handshake coincides with a capture edge -> level stays 16, drop_cnt unchanged, new record appears last.
5. TRACE_TRIG_EN, trig_pc=0x10, PC stepping by 4 from 0 -> state=WAIT until pc=0x10, first drained word=0x10, state=CAPTURE.
6. Mid-drain with level=5, pull rst low between edges -> out_valid=0, level=0, state=IDLE, drop_cnt=0 immediately, without a clock edge.
